if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/if_stage.sv | 114 +++++++++++
 tb/tb_if_stage.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// instruction width, bubble word and PC step.
package if_stage_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'b0;
  localparam logic [31:0] PC_INCR   = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one memory request at a time, presents each
// returned word for one cycle (longer under hazard), and redirects on flush.
//
// Memory handshake: a request is accepted on a cycle where imem_req_o=1 and
// imem_gnt_i=1; imem_gnt_i is ignored while imem_req_o=0. Exactly one response
// (imem_rvalid_i=1) follows each accepted request; rvalid outside WAIT/DROP is
// ignored. Downstream: valid_o=1 marks a real instruction; hazard_i=1 holds it.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                hazard_i,
  input  logic                flush_i,
  input  logic [31:0]         br_target_i,
  output logic                imem_req_o,
  output logic [31:0]         imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [INSTR_W-1:0]  imem_rdata_i,
  output logic [31:0]         pc_o,
  output logic [INSTR_W-1:0]  instr_o,
  output logic                valid_o,
  output fetch_state_e        dbg_state_o
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               imem_req_q, imem_req_d;
  logic               gnt_ok;

  // Next-state, presentation and request decisions for the following cycle.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    gnt_ok     = imem_req_q && imem_gnt_i;

    // A presented instruction leaves after one cycle unless downstream stalls.
    if (valid_q && !hazard_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ:  if (gnt_ok) state_d = ST_WAIT;
      ST_WAIT: begin
        // valid_q is always 0 here: requests are only issued once the previous
        // instruction has left, so the response can always be taken.
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
          if (!flush_i) begin
            pc_d       = fetch_pc_q;
            instr_d    = imem_rdata_i;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_INCR;
          end
        end else if (flush_i) begin
          state_d = ST_DROP;
        end
      end
      // A flush arriving together with the stale response still retires it,
      // otherwise no further response would ever release the FSM.
      ST_DROP: if (imem_rvalid_i) state_d = ST_REQ;
      default: state_d = ST_IDLE;
    endcase

    if (flush_i) begin
      fetch_pc_d = align_pc(br_target_i);
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      if (state_q == ST_REQ && gnt_ok) state_d = ST_DROP;
    end

    // Request only once nothing is presented: keeps one fetch in flight and
    // never lets a response collide with a held instruction.
    imem_req_d = (state_d == ST_REQ) && !valid_d;
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      pc_q       <= 32'b0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      imem_req_q <= imem_req_d;
    end
  end

  assign imem_req_o  = imem_req_q;
  assign imem_addr_o = fetch_pc_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign valid_o     = valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by a randomized memory and
// hazard phase scored against a transaction-level expected queue.
module tb_if_stage;
  import if_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  logic        hazard_i, flush_i, imem_gnt_i, imem_rvalid_i;
  logic [31:0] br_target_i, imem_rdata_i;

  logic         imem_req_o,  imem_req2;
  logic [31:0]  imem_addr_o, imem_addr2;
  logic [31:0]  pc_o, pc2, instr_o, instr2;
  logic         valid_o, valid2;
  fetch_state_e dbg_state_o, dbg_state2;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .hazard_i(hazard_i), .flush_i(flush_i),
    .br_target_i(br_target_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .instr_o(instr_o), .valid_o(valid_o), .dbg_state_o(dbg_state_o)
  );

  // Second instance with a wrapping reset PC, fed the same inputs.
  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .hazard_i(hazard_i), .flush_i(flush_i),
    .br_target_i(br_target_i), .imem_req_o(imem_req2), .imem_addr_o(imem_addr2),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc2), .instr_o(instr2), .valid_o(valid2), .dbg_state_o(dbg_state2)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard / model state ----------------
  logic [63:0] exp_q[$];        // {pc, instr} of each word the memory returned
  logic [31:0] exp_fetch_pc;
  logic        mem_busy;
  int          mem_delay;
  logic [31:0] mem_addr;
  logic        prev_valid, prev_hz;
  logic [31:0] prev_pc, prev_instr;
  logic        drain;
  int          n_pres;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    hazard_i = 1'b0; flush_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    tick();
    tick();
  endtask

  // Grant the pending request, return word next cycle, check the presentation.
  task automatic fetch(input logic [31:0] word, input logic [31:0] exp_pc,
                       input logic [31:0] exp_pc2);
    chk("fetch_req", {31'b0, imem_req_o}, 32'd1);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    chk("wait_req_low", {31'b0, imem_req_o}, 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = word;
    tick();
    imem_rvalid_i = 1'b0;
    chk("pres_valid", {31'b0, valid_o}, 32'd1);
    chk("pres_pc",    pc_o,    exp_pc);
    chk("pres_instr", instr_o, word);
    chk("pres_req",   {31'b0, imem_req_o}, 32'd0);
    chk("wrap_pc",    pc2,     exp_pc2);
  endtask

  // One cycle of the randomized phase: score outputs, then drive memory/hazard.
  task automatic auto_step();
    logic [63:0] e;
    if (prev_valid && prev_hz) begin
      chk("hold_valid", {31'b0, valid_o}, 32'd1);
      chk("hold_pc",    pc_o,    prev_pc);
      chk("hold_instr", instr_o, prev_instr);
    end else if (prev_valid) begin
      chk("one_cycle", {31'b0, valid_o}, 32'd0);
    end else if (valid_o) begin
      n_pres++;
      chk("q_nonempty", {31'b0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rnd_pc",    pc_o,    e[63:32]);
        chk("rnd_instr", instr_o, e[31:0]);
      end
    end
    if (!valid_o) chk("bubble", instr_o, 32'd0);
    prev_valid = valid_o; prev_pc = pc_o; prev_instr = instr_o;

    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    if (mem_busy) begin
      if (mem_delay == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = $urandom;
        exp_q.push_back({mem_addr, imem_rdata_i});
        mem_busy = 1'b0;
      end else begin
        mem_delay--;
      end
    end else begin
      // Stray responses outside WAIT/DROP must be ignored.
      if ($urandom_range(0, 7) == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_0000 | $urandom_range(0, 255);
      end
      if (!drain && imem_req_o && $urandom_range(0, 2) != 0) begin
        chk("rnd_addr", imem_addr_o, exp_fetch_pc);
        imem_gnt_i   = 1'b1;
        mem_addr     = exp_fetch_pc;
        exp_fetch_pc = exp_fetch_pc + 32'd4;
        mem_busy     = 1'b1;
        mem_delay    = $urandom_range(0, 3);
      end
    end
    hazard_i = drain ? 1'b0 : ($urandom_range(0, 3) == 0);
    prev_hz  = hazard_i;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------- directed steps then random phase ----------------
  initial begin
    br_target_i = 32'b0; imem_rdata_i = 32'b0; drain = 1'b0; n_pres = 0;
    do_reset();
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc",    pc_o, 32'd0);
    chk("rst_req",   {31'b0, imem_req_o}, 32'd0);
    chk("rst_addr",  imem_addr_o, 32'd0);
    chk("rst_state", {30'b0, dbg_state_o}, {30'b0, ST_IDLE});
    chk("rst_addr_wrap", imem_addr2, 32'hFFFF_FFFC);
    sys_rst = 1'b0;
    tick();
    chk("first_req",  {31'b0, imem_req_o}, 32'd1);
    chk("first_addr", imem_addr_o, 32'd0);

    // Two back-to-back fetches, each presented one cycle, 3-cycle spacing.
    fetch(32'hA000_000A, 32'd0, 32'hFFFF_FFFC);
    tick();
    chk("a_drop_valid", {31'b0, valid_o}, 32'd0);
    chk("a_drop_instr", instr_o, 32'd0);
    chk("a_drop_pc",    pc_o, 32'd0);
    chk("b_addr",       imem_addr_o, 32'd4);
    fetch(32'hB000_000B, 32'd4, 32'd0);
    tick();
    chk("b_drop_valid", {31'b0, valid_o}, 32'd0);
    chk("c_addr",       imem_addr_o, 32'd8);

    // Hazard holds the presented instruction for 4 cycles.
    fetch(32'hC000_000C, 32'd8, 32'd4);
    hazard_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hz_valid", {31'b0, valid_o}, 32'd1);
      chk("hz_pc",    pc_o, 32'd8);
      chk("hz_instr", instr_o, 32'hC000_000C);
      chk("hz_req",   {31'b0, imem_req_o}, 32'd0);
    end
    hazard_i = 1'b0;
    tick();
    chk("hz_rel_valid", {31'b0, valid_o}, 32'd0);
    chk("hz_rel_req",   {31'b0, imem_req_o}, 32'd1);
    chk("hz_rel_addr",  imem_addr_o, 32'd12);

    // Flush in WAIT: stale response dropped, refetch at aligned target.
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    flush_i = 1'b1; br_target_i = 32'h0000_0103;
    tick();
    flush_i = 1'b0;
    chk("drop_state", {30'b0, dbg_state_o}, {30'b0, ST_DROP});
    chk("drop_req",   {31'b0, imem_req_o}, 32'd0);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h5A5A_5A5A;
    tick();
    imem_rvalid_i = 1'b0;
    chk("stale_valid", {31'b0, valid_o}, 32'd0);
    chk("stale_instr", instr_o, 32'd0);
    chk("redir_req",   {31'b0, imem_req_o}, 32'd1);
    chk("redir_addr",  imem_addr_o, 32'h0000_0100);
    chk("redir_addr_wrap", imem_addr2, 32'h0000_0100);

    // Flush beats hazard while an instruction is presented.
    fetch(32'hD000_000D, 32'h100, 32'h100);
    flush_i = 1'b1; hazard_i = 1'b1; br_target_i = 32'h0000_0200;
    tick();
    flush_i = 1'b0; hazard_i = 1'b0;
    chk("fh_valid", {31'b0, valid_o}, 32'd0);
    chk("fh_instr", instr_o, 32'd0);
    chk("fh_pc",    pc_o, 32'h100);
    chk("fh_addr",  imem_addr_o, 32'h200);
    chk("fh_req",   {31'b0, imem_req_o}, 32'd1);

    // Reset in WAIT; the late response lands in IDLE and is ignored.
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("mrst_state", {30'b0, dbg_state_o}, {30'b0, ST_IDLE});
    chk("mrst_req",   {31'b0, imem_req_o}, 32'd0);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0BAD_0BAD;
    tick();
    imem_rvalid_i = 1'b0;
    chk("mrst_valid", {31'b0, valid_o}, 32'd0);
    chk("mrst_addr",  imem_addr_o, 32'd0);
    chk("mrst_addr_wrap", imem_addr2, 32'hFFFF_FFFC);

    // PC wrap on the second instance.
    fetch(32'hE000_000E, 32'd0, 32'hFFFF_FFFC);
    tick();
    fetch(32'hF000_000F, 32'd4, 32'd0);

    // Randomized memory latency, grant delay and hazard.
    do_reset();
    sys_rst = 1'b0;
    exp_q.delete();
    exp_fetch_pc = 32'd0; mem_busy = 1'b0; mem_delay = 0;
    prev_valid = 1'b0; prev_hz = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      auto_step();
    end
    drain = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() != 0 || mem_busy || valid_o) begin
        tick();
        auto_step();
      end
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("rnd_progress", {31'b0, (n_pres > 100)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
